// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: instruction fetch stage sitting behind the PC register.
// Issues the PC to instruction memory (req/gnt), keeps returned words tagged
// with their PC in an in-order queue, and presents them to decode (valid/ready).
// A redirect (flush) empties the queue and swallows stale in-flight responses.
// Optional feature macro: IFQ_ALIGN_CHECK_EN (misaligned PCs become exception
// entries instead of memory requests).
module instr_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] pc,
    output logic        pc_advance,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_exc,
    input  logic        id_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] ONE_P   = PW'(1);
    localparam logic [PW-1:0] ZERO_P  = {PW{1'b0}};

    logic [31:0]      pc_mem_r    [DEPTH];
    logic [31:0]      instr_mem_r [DEPTH];
    logic [DEPTH-1:0] filled_r;
    logic [DEPTH-1:0] filled_n_s;
    logic [PW-1:0]    wr_r, fill_r, rd_r, discard_r;
    logic [PW-1:0]    wr_n_s, fill_n_s, rd_n_s, discard_n_s;
    logic [PW-1:0]    used_s, inflight_s;
    logic [AW-1:0]    wr_idx_s, fill_idx_s, rd_idx_s;
    logic             room_s, misalign_s, req_issue_s, exc_issue_s;
    logic             pop_s, resp_s, resp_keep_s;

    assign wr_idx_s   = wr_r[AW-1:0];
    assign fill_idx_s = fill_r[AW-1:0];
    assign rd_idx_s   = rd_r[AW-1:0];
    assign used_s     = wr_r - rd_r;

    // An entry can be reserved only out of reset, outside a redirect, with space left.
    assign room_s      = Reset & ~flush & (used_s < DEPTH_P);
`ifdef IFQ_ALIGN_CHECK_EN
    assign misalign_s  = (pc[1:0] != 2'b00);
`else
    assign misalign_s  = 1'b0;
`endif
    assign imem_req    = room_s & ~misalign_s;
    assign imem_addr   = pc;
    assign req_issue_s = imem_req & imem_gnt;
    assign exc_issue_s = room_s & misalign_s;
    assign pc_advance  = req_issue_s | exc_issue_s;

    // Responses in a flush cycle are always dropped; otherwise pending discards come first.
    assign resp_s      = imem_rvalid & ~flush;
    assign resp_keep_s = resp_s & (discard_r == ZERO_P);

    assign if_valid = filled_r[rd_idx_s];
    assign if_instr = instr_mem_r[rd_idx_s];
    assign if_pc    = pc_mem_r[rd_idx_s];
    assign pop_s    = if_valid & id_ready & ~flush;

`ifdef IFQ_ALIGN_CHECK_EN
    logic [DEPTH-1:0] exc_r;
    logic [PW-1:0]    scan_s;

    assign if_exc = exc_r[rd_idx_s] & if_valid;

    // Count real memory requests outstanding: unfilled entries between fill and wr.
    always_comb begin
        inflight_s = ZERO_P;
        scan_s     = fill_r;
        for (int i = 0; i < DEPTH; i++) begin
            scan_s = fill_r + PW'(i);
            if ((PW'(i) < (wr_r - fill_r)) && !filled_r[scan_s[AW-1:0]]) begin
                inflight_s = inflight_s + ONE_P;
            end else begin
                inflight_s = inflight_s;
            end
        end
    end
`else
    assign if_exc     = 1'b0;
    assign inflight_s = wr_r - fill_r;
`endif

    // Next-state for pointers, filled bits and the stale-response discard counter.
    always_comb begin
        wr_n_s      = wr_r;
        fill_n_s    = fill_r;
        rd_n_s      = rd_r;
        discard_n_s = discard_r;
        filled_n_s  = filled_r;
        if (flush) begin
            wr_n_s      = ZERO_P;
            fill_n_s    = ZERO_P;
            rd_n_s      = ZERO_P;
            filled_n_s  = {DEPTH{1'b0}};
            discard_n_s = discard_r + inflight_s - (imem_rvalid ? ONE_P : ZERO_P);
        end else begin
            if (pop_s) begin
                filled_n_s[rd_idx_s] = 1'b0;
                rd_n_s               = rd_r + ONE_P;
            end else begin
                rd_n_s = rd_r;
            end
            if (resp_keep_s) begin
                filled_n_s[fill_idx_s] = 1'b1;
                fill_n_s               = fill_r + ONE_P;
            end else if (resp_s) begin
                discard_n_s = discard_r - ONE_P;
            end else begin
                discard_n_s = discard_r;
            end
            if (pc_advance) begin
                wr_n_s = wr_r + ONE_P;
            end else begin
                wr_n_s = wr_r;
            end
            if (exc_issue_s) begin
                filled_n_s[wr_idx_s] = 1'b1;
            end else begin
                filled_n_s = filled_n_s;
            end
`ifdef IFQ_ALIGN_CHECK_EN
            // fill must always rest on the oldest entry still awaiting memory data.
            for (int i = 0; i < DEPTH; i++) begin
                if ((fill_n_s != wr_n_s) && filled_n_s[fill_n_s[AW-1:0]]) begin
                    fill_n_s = fill_n_s + ONE_P;
                end else begin
                    fill_n_s = fill_n_s;
                end
            end
`endif
        end
    end

    // Control state register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_r      <= ZERO_P;
            fill_r    <= ZERO_P;
            rd_r      <= ZERO_P;
            discard_r <= ZERO_P;
            filled_r  <= {DEPTH{1'b0}};
        end else begin
            wr_r      <= wr_n_s;
            fill_r    <= fill_n_s;
            rd_r      <= rd_n_s;
            discard_r <= discard_n_s;
            filled_r  <= filled_n_s;
        end
    end

    // Entry payload: PC captured at issue, instruction word captured on a kept response.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]    <= 32'h0000_0000;
                instr_mem_r[i] <= 32'h0000_0000;
            end
`ifdef IFQ_ALIGN_CHECK_EN
            exc_r <= {DEPTH{1'b0}};
`endif
        end else begin
            if (pc_advance) begin
                pc_mem_r[wr_idx_s] <= pc;
`ifdef IFQ_ALIGN_CHECK_EN
                exc_r[wr_idx_s] <= exc_issue_s;
                if (exc_issue_s) begin
                    instr_mem_r[wr_idx_s] <= 32'h0000_0000;
                end
`endif
            end
            if (resp_keep_s) begin
                instr_mem_r[fill_idx_s] <= imem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: in-order memory model with a
// configurable latency plus a scoreboard of expected {pc, instr, exc} entries.
module tb_instr_fetch_queue;
    logic        Clk = 1'b0;
    logic        Reset, pc_advance, flush, imem_req, imem_gnt, imem_rvalid;
    logic        if_valid, if_exc, id_ready;
    logic [31:0] pc, imem_addr, imem_rdata, if_instr, if_pc;

    int errors = 0;
    int checks = 0;
    int lat    = 1;
    int edge_n = 0;
    int grants = 0;
    int pops   = 0;
    bit auto_pc = 1'b1;
    bit obs_req, obs_adv, obs_valid;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; logic exc; } exp_t;
    mreq_t mq[$];
    exp_t  sb[$];

    always #5 Clk = ~Clk;

    instr_fetch_queue #(.DEPTH(4)) dut (
        .Clk(Clk), .Reset(Reset), .pc(pc), .pc_advance(pc_advance), .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .if_instr(if_instr), .if_pc(if_pc), .if_exc(if_exc), .id_ready(id_ready)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle: drive memory response, sample, update model, advance PC.
    task automatic cycle();
        exp_t e;
        logic g, adv, pop, rv;
        if (mq.size() > 0 && mq[0].due <= edge_n) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(mq[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        #1;
        g   = imem_req & imem_gnt;
        adv = pc_advance;
        rv  = imem_rvalid;
        pop = if_valid & id_ready & ~flush;
        obs_req = imem_req; obs_adv = adv; obs_valid = if_valid;
        if (pop) begin
            checks++;
            pops++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got pc=%h instr=%h, want no entry", if_pc, if_instr);
            end else begin
                e = sb.pop_front();
                if (if_pc !== e.pc || if_instr !== e.instr || if_exc !== e.exc) begin
                    errors++;
                    $display("FAIL pop_data: got pc=%h instr=%h exc=%b, want pc=%h instr=%h exc=%b",
                             if_pc, if_instr, if_exc, e.pc, e.instr, e.exc);
                end
            end
        end
        if (g) begin
            mq.push_back('{addr: pc, due: edge_n + lat});
            sb.push_back('{pc: pc, instr: instr_of(pc), exc: 1'b0});
            grants++;
        end else if (adv) begin
            sb.push_back('{pc: pc, instr: 32'h0, exc: 1'b1});
        end
        if (flush) sb.delete();
        @(posedge Clk);
        edge_n++;
        if (rv) mq.delete(0);
        @(negedge Clk);
        if (adv && auto_pc) pc = pc + 32'd4;
    endtask

    task automatic drain();
        int n = 0;
        imem_gnt = 1'b0; id_ready = 1'b1; flush = 1'b0;
        while ((sb.size() != 0 || mq.size() != 0) && n < 30) begin
            cycle();
            n++;
        end
        checks++;
        if (sb.size() != 0 || mq.size() != 0 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain: got sb=%0d mq=%0d if_valid=%b, want 0 0 0", sb.size(), mq.size(), if_valid);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0; pc = 32'h3000; imem_gnt = 1'b1; id_ready = 1'b1;
        flush = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk); #1;
            checks++;
            if (imem_req !== 1'b0 || if_valid !== 1'b0 || pc_advance !== 1'b0 ||
                if_instr !== 32'h0 || if_pc !== 32'h0 || if_exc !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: got req=%b valid=%b adv=%b instr=%h pc=%h, want all 0",
                         imem_req, if_valid, pc_advance, if_instr, if_pc);
            end
        end
        imem_gnt = 1'b0;
        Reset = 1'b1;
        @(negedge Clk); #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
            errors++;
            $display("FAIL reset_release: got req=%b addr=%h, want 1 00003000", imem_req, imem_addr);
        end
    endtask

    task automatic test_streaming();
        lat = 1; auto_pc = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1; flush = 1'b0;
        grants = 0; pops = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (i >= 2) begin
                checks++;
                if (obs_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_valid: cycle %0d got if_valid=%b, want 1", i, obs_valid);
                end
            end
        end
        checks++;
        if (grants != 12 || pc !== 32'h3030) begin
            errors++;
            $display("FAIL stream_grants: got grants=%0d pc=%h, want 12 00003030", grants, pc);
        end
        drain();
        checks++;
        if (pops != 12) begin
            errors++;
            $display("FAIL stream_pops: got %0d, want 12", pops);
        end
    endtask

    task automatic test_backpressure();
        lat = 1; pc = 32'h3200; imem_gnt = 1'b1; id_ready = 1'b0; grants = 0; pops = 0;
        for (int i = 0; i < 8; i++) cycle();
        checks++;
        if (grants != 4 || obs_req !== 1'b0 || obs_adv !== 1'b0 || pc !== 32'h3210) begin
            errors++;
            $display("FAIL bp_full: got grants=%0d req=%b adv=%b pc=%h, want 4 0 0 00003210",
                     grants, obs_req, obs_adv, pc);
        end
        id_ready = 1'b1;
        cycle();
        id_ready = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        checks++;
        if (grants != 5 || pops != 1 || obs_req !== 1'b0) begin
            errors++;
            $display("FAIL bp_one_more: got grants=%0d pops=%0d req=%b, want 5 1 0", grants, pops, obs_req);
        end
        drain();
        checks++;
        if (pops != 5) begin
            errors++;
            $display("FAIL bp_pops: got %0d, want 5", pops);
        end
    endtask

    task automatic test_flush();
        lat = 3; pc = 32'h3300; imem_gnt = 1'b1; id_ready = 1'b1; grants = 0; pops = 0;
        cycle(); cycle();
        flush = 1'b1;
        cycle();
        checks++;
        if (obs_req !== 1'b0 || obs_adv !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_issue: got req=%b adv=%b, want 0 0", obs_req, obs_adv);
        end
        flush = 1'b0; pc = 32'h3100;
        cycle();
        imem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (obs_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_stale: step %0d got if_valid=%b, want 0", i, obs_valid);
            end
        end
        drain();
        checks++;
        if (grants != 3 || pops != 1) begin
            errors++;
            $display("FAIL flush_refetch: got grants=%0d pops=%0d, want 3 1", grants, pops);
        end
    endtask

    task automatic test_simultaneous();
        lat = 1; pc = 32'h3400; imem_gnt = 1'b1; id_ready = 1'b0; grants = 0; pops = 0;
        cycle(); cycle(); cycle();
        id_ready = 1'b1;
        cycle();
        checks++;
        if (obs_valid !== 1'b1 || obs_req !== 1'b1 || grants != 4 || pops != 1) begin
            errors++;
            $display("FAIL simul_events: got valid=%b req=%b grants=%0d pops=%0d, want 1 1 4 1",
                     obs_valid, obs_req, grants, pops);
        end
        id_ready = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        checks++;
        if (grants != 5 || obs_req !== 1'b0) begin
            errors++;
            $display("FAIL simul_used: got grants=%0d req=%b, want 5 0", grants, obs_req);
        end
        drain();
        // flush in the same cycle as a response
        lat = 2; pc = 32'h3500; imem_gnt = 1'b1; id_ready = 1'b0; grants = 0; pops = 0;
        cycle(); cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0; pc = 32'h3510; id_ready = 1'b1;
        cycle();
        checks++;
        if (obs_valid !== 1'b0 || grants != 3) begin
            errors++;
            $display("FAIL flush_rvalid_a: got valid=%b grants=%0d, want 0 3", obs_valid, grants);
        end
        imem_gnt = 1'b0;
        cycle();
        checks++;
        if (obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_rvalid_b: got valid=%b, want 0", obs_valid);
        end
        drain();
        checks++;
        if (pops != 1) begin
            errors++;
            $display("FAIL flush_rvalid_pops: got %0d, want 1", pops);
        end
    endtask

    task automatic test_reset_mid();
        lat = 2; auto_pc = 1'b1; pc = 32'h3700; imem_gnt = 1'b1; id_ready = 1'b0; flush = 1'b0;
        cycle(); cycle();
        Reset = 1'b0; mq.delete(); sb.delete(); imem_rvalid = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0 || pc_advance !== 1'b0 || if_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: got req=%b valid=%b adv=%b pc=%h, want 0 0 0 0",
                     imem_req, if_valid, pc_advance, if_pc);
        end
        @(posedge Clk); edge_n++;
        @(negedge Clk);
        Reset = 1'b1; pc = 32'h3800; grants = 0; pops = 0;
        cycle();
        drain();
        checks++;
        if (grants != 1 || pops != 1) begin
            errors++;
            $display("FAIL reset_mid_resume: got grants=%0d pops=%0d, want 1 1", grants, pops);
        end
    endtask

`ifdef IFQ_ALIGN_CHECK_EN
    task automatic test_align();
        lat = 2; auto_pc = 1'b0; imem_gnt = 1'b1; id_ready = 1'b1; grants = 0; pops = 0;
        pc = 32'h3600;
        cycle();
        pc = 32'h3602;
        cycle();
        checks++;
        if (obs_req !== 1'b0 || obs_adv !== 1'b1) begin
            errors++;
            $display("FAIL align_issue: got req=%b adv=%b, want 0 1", obs_req, obs_adv);
        end
        pc = 32'h3608;
        cycle();
        drain();
        checks++;
        if (pops != 3 || grants != 2) begin
            errors++;
            $display("FAIL align_pops: got pops=%0d grants=%0d, want 3 2", pops, grants);
        end
        auto_pc = 1'b1;
    endtask
`endif

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_simultaneous();
        test_reset_mid();
`ifdef IFQ_ALIGN_CHECK_EN
        test_align();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
